// File: rtl/pz_pkg.sv
// Shared definitions for the pz sequential accumulator: FSM state encoding
// and default entry/result widths.
package pz_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } pz_state_e;

    localparam int PZ_DATA_W = 16;
    localparam int PZ_OUT_W  = 16;

endpackage

// File: rtl/pz_saturate.sv
// Combinational range reduction of the wide accumulator to the signed OUT_W
// result: flags overflow and either clamps or truncates.
module pz_saturate #(
    parameter int ACC_W  = 19,
    parameter int OUT_W  = 16,
    parameter int SAT_EN = 1
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [OUT_W-1:0] result,
    output logic                    ovf
);

    // Compare in a width that holds both ACC_W and OUT_W values, whichever is larger.
    localparam int CW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic signed [CW-1:0] MAX_X = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CW-1:0] MIN_X = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [CW-1:0] acc_x;
    logic                 above;
    logic                 below;

    assign acc_x = CW'(acc);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        above  = acc_x > MAX_X;
        below  = acc_x < MIN_X;
        ovf    = above | below;
        result = acc_x[OUT_W-1:0];
        if (SAT_EN != 0) begin
            if (above) begin
                result = MAX_X[OUT_W-1:0];
            end else if (below) begin
                result = MIN_X[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pz_seq_accumulator.sv
// Sequential accumulator over a snapshot of REG_FILE_SIZE signed pz entries,
// one entry per cycle, producing a saturated or wrapped signed sum.
module pz_seq_accumulator
    import pz_pkg::*;
#(
    parameter int REG_FILE_SIZE = 2,
    parameter int DATA_W        = PZ_DATA_W,
    parameter int OUT_W         = PZ_OUT_W,
    parameter int SAT_EN        = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            mode,
    input  logic [DATA_W*REG_FILE_SIZE-1:0] flat_pz,
    output logic                            busy,
    output logic                            out_valid,
    output logic [OUT_W-1:0]                acc_pz,
    output logic                            ovf
);

    localparam int ACC_W = DATA_W + $clog2(REG_FILE_SIZE) + 1;
    localparam int IDX_W = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_FILE_SIZE - 1);

    pz_state_e                       state_q;
    pz_state_e                       state_d;
    logic [DATA_W*REG_FILE_SIZE-1:0] snap_q;
    logic                            mode_q;
    logic [IDX_W-1:0]                idx_q;
    logic signed [ACC_W-1:0]         acc_q;
    logic signed [DATA_W-1:0]        entry;
    logic signed [ACC_W-1:0]         entry_x;
    logic signed [ACC_W-1:0]         term;
    logic [OUT_W-1:0]                sat_result;
    logic                            sat_ovf;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Magnitude is taken after widening, so -2^(DATA_W-1) negates without wrapping.
    always_comb begin
        entry   = snap_q[DATA_W*idx_q +: DATA_W];
        entry_x = ACC_W'(entry);
        term    = (mode_q && entry_x[ACC_W-1]) ? -entry_x : entry_x;
    end

    // NOTE: the snapshot is pure data storage, loaded before it is ever read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            snap_q <= flat_pz;
            mode_q <= mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            acc_pz    <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + term;
                    idx_q <= idx_q + 1'b1;
                end
                DONE: begin
                    acc_pz    <= sat_result;
                    ovf       <= sat_ovf;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    pz_saturate #(
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .SAT_EN (SAT_EN)
    ) u_saturate (
        .acc    (acc_q),
        .result (sat_result),
        .ovf    (sat_ovf)
    );

endmodule

// File: doc/pz_seq_accumulator.md
PZ_SEQ_ACCUMULATOR -- requirements
Module: pz_seq_accumulator

Interface
REQ-001 SHALL have parameter REG_FILE_SIZE, default 2, giving the number of pz entries, range 1..64.
REQ-002 SHALL have parameter DATA_W, default 16, giving the signed width of each pz entry.
REQ-003 SHALL have parameter OUT_W, default 16, giving the signed width of acc_pz.
REQ-004 SHALL have parameter SAT_EN, default 1: 1 = saturate the result to OUT_W, 0 = wrap (truncate) it.
REQ-005 SHALL derive localparam ACC_W = DATA_W + clog2(REG_FILE_SIZE) + 1 for the internal accumulator.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: request a new accumulation.
REQ-009 SHALL have port mode, input, 1 bit: 0 = signed sum, 1 = sum of absolute values; sampled with start.
REQ-010 SHALL have port flat_pz, input, DATA_W*REG_FILE_SIZE bits: entry i occupies bits [DATA_W*i +: DATA_W], signed.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-013 SHALL have port acc_pz, output, OUT_W bits: signed result, held until the next result or reset.
REQ-014 SHALL have port ovf, output, 1 bit: the full sum fell outside the signed OUT_W range; updated together with acc_pz.

Function
REQ-015 SHALL implement the state machine IDLE -> ACCUM -> DONE -> IDLE.
REQ-016 In IDLE, start=1 SHALL snapshot flat_pz and mode, clear acc to 0 and index to 0, and move to ACCUM.
REQ-017 In ACCUM, each cycle SHALL add the snapshot entry at index (sign-extended to ACC_W, or its magnitude if mode=1) to acc and increment index.
REQ-018 In ACCUM, when index = REG_FILE_SIZE-1 the state machine SHALL perform that last add and move to DONE.
REQ-019 In DONE, the block SHALL register acc_pz and ovf from acc, pulse out_valid for exactly one cycle, and return to IDLE.
REQ-020 Latency: if start is sampled at edge T, out_valid SHALL be high in the cycle following edge T+REG_FILE_SIZE+1, giving a throughput of one result per REG_FILE_SIZE+2 cycles.
REQ-021 start SHALL be ignored in ACCUM and DONE; it is not queued.
REQ-022 flat_pz changes after the snapshot SHALL NOT affect the in-flight result.
REQ-023 The magnitude of the most negative value (-2^(DATA_W-1)) SHALL be 2^(DATA_W-1) exactly, with no wrap, using ACC_W headroom.
REQ-024 Overflow handling: if acc is above the OUT_W signed maximum or below the OUT_W signed minimum, ovf SHALL be 1.
REQ-025 On overflow with SAT_EN=1, acc_pz SHALL be clamped to the OUT_W maximum or minimum; with SAT_EN=0, acc_pz SHALL be acc[OUT_W-1:0].
REQ-026 With REG_FILE_SIZE=1, ACCUM SHALL last exactly one cycle.
REQ-027 acc SHALL never overflow ACC_W for any input.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL go to IDLE with acc=0, index=0, busy=0, out_valid=0, acc_pz=0 and ovf=0.
REQ-029 rst SHALL take priority over start; rst during ACCUM or DONE SHALL abort the operation with no out_valid pulse.
REQ-030 The first start after rst deasserts SHALL behave exactly as in REQ-016.

Structure
REQ-031 Package pz_pkg SHALL hold the state encoding (IDLE, ACCUM, DONE) and the default DATA_W and OUT_W constants.
REQ-032 One combinational sub-module, pz_saturate (parameters ACC_W and OUT_W; outputs the clamped or wrapped value and ovf), SHALL implement REQ-024 and REQ-025.

Verification
REQ-033 N=2, mode=0, pz={3,-5}, start -> out_valid 3 cycles after the start edge, acc_pz=0xFFFE, ovf=0.
REQ-034 N=2, SAT_EN=1, pz={0x7FFF,0x0001} -> acc_pz=0x7FFF, ovf=1; with SAT_EN=0 -> acc_pz=0x8000, ovf=1.
REQ-035 N=2, mode=1, pz={-4,6} -> acc_pz=10; pz={0x8000,0x8000}, SAT_EN=1 -> acc_pz=0x7FFF, ovf=1.
REQ-036 N=4, pz={1,2,3,4}, start held high 8 cycles -> two results of 10, with out_valid pulses 6 cycles apart; start held while busy is ignored.
REQ-037 rst pulsed during ACCUM -> no out_valid, acc_pz=0, busy=0 the next cycle; the next start yields a correct sum.
REQ-038 flat_pz changed during ACCUM (N=2, {3,-5} -> {100,100}) -> result still 0xFFFE.
